serial_bit_feeder: RTL

//  Parallel-to-serial stage upstream of the two-consecutive-ones Mealy detector.

---
 rtl/serial_pkg.sv | 5 +
 rtl/serial_bit_feeder_if.sv | 12 +
 rtl/serial_bit_counter.sv | 16 +
 rtl/serial_bit_feeder.sv | 83 ++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: shared state encoding and default word width for the serial bit feeder
package serial_pkg;
  localparam int DEFAULT_WIDTH = 8;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_PARITY = 2'd2} state_t;
endpackage

// File: rtl/serial_bit_feeder_if.sv
// serial_bit_feeder_if: word handshake (din/din_valid/din_ready), abort, and serial burst outputs (w_out/w_valid/done)
interface serial_bit_feeder_if import serial_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH);
  logic [WIDTH-1:0] din;
  logic din_valid;
  logic din_ready;
  logic abort;
  logic w_out;
  logic w_valid;
  logic done;
  modport master(output din, din_valid, abort, input din_ready, w_out, w_valid, done);
  modport slave(input din, din_valid, abort, output din_ready, w_out, w_valid, done);
endinterface

// File: rtl/serial_bit_counter.sv
// serial_bit_counter: clog2(WIDTH)-bit up-counter; ports clk, rst, clr_i, en_i, last_bit_o (count==WIDTH-1)
module serial_bit_counter #(parameter int WIDTH = 8) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic last_bit_o
);
  localparam int CW = $clog2(WIDTH);
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst || clr_i) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_q + CW'(1);
  end
  assign last_bit_o = cnt_q == CW'(WIDTH - 1);
endmodule

// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: word-to-serial burst stage; ports clk, reset (sync, active-high), bus (slave: din/din_valid/din_ready/abort/w_out/w_valid/done); SERIAL_PARITY_EN adds an even-parity bit
module serial_bit_feeder import serial_pkg::*; #(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic clk,
  input logic reset,
  serial_bit_feeder_if.slave bus
);
  state_t state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d, sr_shift;
  logic w_out_q, w_out_d, w_valid_q, w_valid_d, done_q, done_d;
  logic par_q, par_d;
  logic load, last_bit;
  function automatic logic head(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction
  assign bus.din_ready = (state_q == ST_IDLE) && !reset;
  assign load = bus.din_valid && bus.din_ready;
  assign sr_shift = MSB_FIRST ? sr_q << 1 : sr_q >> 1;
  serial_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk(clk),
    .rst(reset),
    .clr_i(load),
    .en_i(state_q == ST_SHIFT && !last_bit),
    .last_bit_o(last_bit)
  );
  always_comb begin
    state_d = state_q;
    sr_d = sr_q;
    par_d = par_q;
    w_out_d = 1'b0;
    w_valid_d = 1'b0;
    done_d = 1'b0;
    if (state_q == ST_IDLE) begin
      if (load) begin
        state_d = ST_SHIFT;
        sr_d = bus.din;
        w_out_d = head(bus.din);
        w_valid_d = 1'b1;
`ifdef SERIAL_PARITY_EN
        par_d = ^bus.din;
`endif
      end
    end else if (bus.abort) state_d = ST_IDLE;
    else if (state_q == ST_SHIFT && !last_bit) begin
      sr_d = sr_shift;
      w_out_d = head(sr_shift);
      w_valid_d = 1'b1;
    end
`ifdef SERIAL_PARITY_EN
    else if (state_q == ST_SHIFT) begin
      state_d = ST_PARITY;
      w_out_d = par_q;
      w_valid_d = 1'b1;
    end
`endif
    else begin
      state_d = ST_IDLE;
      done_d = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sr_q <= '0;
      par_q <= 1'b0;
      w_out_q <= 1'b0;
      w_valid_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      par_q <= par_d;
      w_out_q <= w_out_d;
      w_valid_q <= w_valid_d;
      done_q <= done_d;
    end
  end
  assign bus.w_out = w_out_q;
  assign bus.w_valid = w_valid_q;
  assign bus.done = done_q;
endmodule
